// File: rtl/mips_trace_buffer_if.sv
`default_nettype none
// ============================================================================
// Interface : mips_trace_buffer_if
// Purpose   : Retire-capture and drain signals of the MIPS trace buffer.
//             master = the side feeding retire records and reading entries
//             (core glue / debug host); slave = the trace buffer itself.
// Signals   : cap_valid, cap_pc, cap_instr, cap_wen, cap_wreg, cap_wdata
//             (capture side); rd_ready, rd_valid, rd_pc, rd_instr, rd_wen,
//             rd_wreg, rd_wdata (drain side).
// Revision  : 1.0 - initial release
// ============================================================================
interface mips_trace_buffer_if #(
   parameter int XLEN = 32
);
   logic            cap_valid;
   logic [XLEN-1:0] cap_pc;
   logic [XLEN-1:0] cap_instr;
   logic            cap_wen;
   logic [4:0]      cap_wreg;
   logic [XLEN-1:0] cap_wdata;

   logic            rd_ready;
   logic            rd_valid;
   logic [XLEN-1:0] rd_pc;
   logic [XLEN-1:0] rd_instr;
   logic            rd_wen;
   logic [4:0]      rd_wreg;
   logic [XLEN-1:0] rd_wdata;

   modport master (
      output cap_valid, cap_pc, cap_instr, cap_wen, cap_wreg, cap_wdata,
      output rd_ready,
      input  rd_valid, rd_pc, rd_instr, rd_wen, rd_wreg, rd_wdata
   );

   modport slave (
      input  cap_valid, cap_pc, cap_instr, cap_wen, cap_wreg, cap_wdata,
      input  rd_ready,
      output rd_valid, rd_pc, rd_instr, rd_wen, rd_wreg, rd_wdata
   );
endinterface
`default_nettype wire

// File: rtl/mips_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module    : mips_trace_buffer
// Purpose   : Retire-trace capture for the single-cycle MIPS core. One entry
//             (PC, instruction, GPR writeback) per retired instruction is
//             stored in a 2**AW-entry ring buffer and drained through a
//             first-word-fall-through valid/ready port.
// Ports     : clk      - rising-edge clock
//             reset    - asynchronous, active-low reset
//             trc      - mips_trace_buffer_if.slave (capture + drain signals)
//             mode     - 0 = stop when full, 1 = wrap (overwrite oldest)
//             arm      - 1-cycle pulse: clear buffer, start a session
//             trig_pc  - trigger PC (only meaningful with TRACE_TRIGGER_EN)
//             count    - entries held, 0..DEPTH
//             overflow - sticky: a record was dropped or overwritten
//             state    - FSM code IDLE=00 WAIT_TRIG=01 CAPTURE=10 DONE=11
// Config    : `define TRACE_TRIGGER_EN -> arm waits in WAIT_TRIG until a
//             retire with cap_pc == trig_pc; otherwise arm starts capture.
// Revision  : 1.0 - initial release
// ============================================================================
module mips_trace_buffer #(
   parameter int AW   = 4,
   parameter int XLEN = 32
) (
   input  wire logic            clk,
   input  wire logic            reset,
   mips_trace_buffer_if.slave   trc,
   input  wire logic            mode,
   input  wire logic            arm,
   input  wire logic [XLEN-1:0] trig_pc,
   output logic      [AW:0]     count,
   output logic                 overflow,
   output logic      [1:0]      state
);
   localparam int          c_DEPTH_INT = 2**AW;
   localparam logic [AW:0] c_DEPTH     = (AW+1)'(c_DEPTH_INT);
   localparam logic [AW:0] c_ONE       = (AW+1)'(1);

   localparam logic [1:0] c_IDLE      = 2'b00;
   localparam logic [1:0] c_WAIT_TRIG = 2'b01;
   localparam logic [1:0] c_CAPTURE   = 2'b10;
   localparam logic [1:0] c_DONE      = 2'b11;

`ifdef TRACE_TRIGGER_EN
   localparam logic [1:0] c_ARM_STATE = c_WAIT_TRIG;
`else
   localparam logic [1:0] c_ARM_STATE = c_CAPTURE;
`endif

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;
   logic [1:0]    r_state;

   logic [XLEN-1:0] r_mem_pc    [c_DEPTH_INT];
   logic [XLEN-1:0] r_mem_instr [c_DEPTH_INT];
   logic [XLEN-1:0] r_mem_wdata [c_DEPTH_INT];
   logic            r_mem_wen   [c_DEPTH_INT];
   logic [4:0]      r_mem_wreg  [c_DEPTH_INT];

   logic          w_pop;
   logic          w_full;
   logic          w_trig_hit;
   logic          w_accept;
   logic          w_write;
   logic          w_overwrite;
   logic          w_drop;
   logic [AW:0]   w_count_nxt;

   // Pops are legal in every state, including IDLE and DONE.
   assign w_pop  = (r_count != '0) && trc.rd_ready;
   assign w_full = (r_count == c_DEPTH);

   // WAIT_TRIG is unreachable without TRACE_TRIGGER_EN, so this term is
   // constant-false there and trig_pc has no effect.
   assign w_trig_hit = (r_state == c_WAIT_TRIG) && (trc.cap_pc == trig_pc);

   // arm wins over a simultaneous retire: the record vanishes silently.
   assign w_accept = !arm && trc.cap_valid &&
                     ((r_state == c_CAPTURE) || w_trig_hit);

   // A full buffer still takes the record when a pop frees the slot in the
   // same cycle, or in wrap mode where the oldest entry is sacrificed.
   assign w_write     = w_accept && (!w_full || w_pop || mode);
   assign w_overwrite = w_accept && w_full && !w_pop && mode;
   assign w_drop      = (w_accept && w_full && !w_pop && !mode) ||
                        (!arm && trc.cap_valid && (r_state == c_DONE));

   always_comb begin
      w_count_nxt = r_count;
      if (w_write && !w_pop && !w_overwrite)
         w_count_nxt = r_count + c_ONE;
      else if (!w_write && w_pop)
         w_count_nxt = r_count - c_ONE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_state    <= c_IDLE;
      end else if (arm) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_state    <= c_ARM_STATE;
      end else begin
         if (w_write)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop || w_overwrite)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
         if (w_overwrite || w_drop)
            r_overflow <= 1'b1;
         // Stop mode ends the session as soon as the buffer is full; the
         // mode in force at the push decides.
         if (w_accept)
            r_state <= (!mode && (w_count_nxt == c_DEPTH)) ? c_DONE : c_CAPTURE;
      end
   end

   // Storage carries no reset; outputs are masked while the buffer is empty.
   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem_pc[r_wr_ptr]    <= trc.cap_pc;
         r_mem_instr[r_wr_ptr] <= trc.cap_instr;
         r_mem_wdata[r_wr_ptr] <= trc.cap_wdata;
         r_mem_wen[r_wr_ptr]   <= trc.cap_wen;
         r_mem_wreg[r_wr_ptr]  <= trc.cap_wreg;
      end
   end

   assign trc.rd_valid = (r_count != '0);
   assign trc.rd_pc    = trc.rd_valid ? r_mem_pc[r_rd_ptr]    : '0;
   assign trc.rd_instr = trc.rd_valid ? r_mem_instr[r_rd_ptr] : '0;
   assign trc.rd_wdata = trc.rd_valid ? r_mem_wdata[r_rd_ptr] : '0;
   assign trc.rd_wen   = trc.rd_valid ? r_mem_wen[r_rd_ptr]   : 1'b0;
   assign trc.rd_wreg  = trc.rd_valid ? r_mem_wreg[r_rd_ptr]  : 5'd0;

   assign count    = r_count;
   assign overflow = r_overflow;
   assign state    = r_state;
endmodule
`default_nettype wire
